// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux frame scanner.
// Holds the scan FSM state encoding and the next-enabled-channel search.
package demux_pkg;

   localparam int SEL_W_DEF = 3;
   localparam int NCH_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   typedef struct packed {
      logic                 found;
      logic [SEL_W_DEF-1:0] index;
   } find_t;

   // Lowest set bit strictly above 'current' for the default 8-channel width.
   function automatic find_t next_set_index(input logic [NCH_DEF-1:0]   mask,
                                            input logic [SEL_W_DEF-1:0] current);
      find_t res;
      res = '0;
      for (int k = NCH_DEF - 1; k >= 0; k--) begin
         if (mask[k] && (k > int'(current))) begin
            res.found = 1'b1;
            res.index = SEL_W_DEF'(k);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/demux_frame_scanner_prio.sv
// Combinational finder for the lowest enabled channel at or above 'from'.
// One instance serves both the first-channel search and the advance search.
module demux_prio_find #(
   parameter int SEL_W = 3
) (
   input  logic [2**SEL_W-1:0] mask,
   input  logic [SEL_W:0]      from,
   output logic [SEL_W-1:0]    index,
   output logic                found
);

   localparam int NCH = 2**SEL_W;

   // Descending scan so the lowest qualifying index is the last one written.
   always_comb begin
      index = '0;
      found = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (mask[k] && ((SEL_W+1)'(k) >= from)) begin
            index = SEL_W'(k);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_frame_scanner.sv
// Serialises an accepted frame onto the demuxif select/q inputs,
// lowest enabled channel first, holding each channel for DWELL cycles.
module demux_frame_scanner
   import demux_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF,
   parameter int DWELL = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2**SEL_W-1:0] in_data,
   input  logic [2**SEL_W-1:0] in_mask,
   output logic [SEL_W-1:0]    select,
   output logic                q,
   output logic                q_valid,
   output logic                busy,
   output logic                frame_done
);

   localparam int NCH = 2**SEL_W;
   localparam int CW  = (DWELL < 2) ? 1 : $clog2(DWELL + 1);

   state_t           state;
   logic [NCH-1:0]   data_reg;
   logic [NCH-1:0]   mask_reg;
   logic [CW-1:0]    cnt;
   logic [NCH-1:0]   find_mask;
   logic [SEL_W:0]   find_from;
   logic [SEL_W-1:0] find_index;
   logic             find_found;

   // In IDLE the finder looks at the offered frame; in SCAN at the captured one.
   assign find_mask = (state == IDLE) ? in_mask : mask_reg;
   assign find_from = (state == IDLE) ? '0 : ({1'b0, select} + (SEL_W+1)'(1));

   demux_prio_find #(.SEL_W(SEL_W)) u_find (
      .mask  (find_mask),
      .from  (find_from),
      .index (find_index),
      .found (find_found)
   );

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         data_reg   <= '0;
         mask_reg   <= '0;
         cnt        <= '0;
         select     <= '0;
         q          <= 1'b0;
         q_valid    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               q          <= 1'b0;
               q_valid    <= 1'b0;
               frame_done <= 1'b0;
               if (in_valid) begin
                  data_reg <= in_data;
                  mask_reg <= in_mask;
                  cnt      <= '0;
                  if (find_found) begin
                     state   <= SCAN;
                     select  <= find_index;
                     q       <= in_data[find_index];
                     q_valid <= 1'b1;
                     busy    <= 1'b1;
                  end else begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (cnt == CW'(DWELL - 1)) begin
                  cnt <= '0;
                  if (find_found) begin
                     select <= find_index;
                     q      <= data_reg[find_index];
                  end else begin
                     state      <= DONE;
                     q          <= 1'b0;
                     q_valid    <= 1'b0;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               frame_done <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_frame_scanner.sv
// Directed self-checking bench for demux_frame_scanner.
// dut1 runs with DWELL=1, dut3 with DWELL=3; both share clock and reset.
module tb_demux_frame_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       v1 = 1'b0, r1;
   logic [7:0] d1 = '0, m1 = '0;
   logic [2:0] sel1;
   logic       q1, qv1, b1, fd1;

   logic       v3 = 1'b0, r3;
   logic [7:0] d3 = '0, m3 = '0;
   logic [2:0] sel3;
   logic       q3, qv3, b3, fd3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   demux_frame_scanner #(.SEL_W(3), .DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_mask(m1),
      .select(sel1), .q(q1), .q_valid(qv1), .busy(b1), .frame_done(fd1)
   );

   demux_frame_scanner #(.SEL_W(3), .DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_data(d3), .in_mask(m3),
      .select(sel3), .q(q3), .q_valid(qv3), .busy(b3), .frame_done(fd3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [7:0] m);
      v1 = v;
      d1 = d;
      m1 = m;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total++; if (sel1 !== 3'd0) begin bad++; $display("[TB] FAIL reset_select got=%0d want=0", sel1); end
      total++; if (q1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_q got=%b want=0", q1); end
      total++; if (qv1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_q_valid got=%b want=0", qv1); end
      total++; if (b1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", b1); end
      total++; if (fd1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done got=%b want=0", fd1); end
      total++; if (r1 !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", r1); end
      total++; if (r3 !== 1'b1 || qv3 !== 1'b0) begin bad++; $display("[TB] FAIL reset_dut3 in_ready=%b q_valid=%b want 1/0", r3, qv3); end
   endtask

   task automatic test_full_frame();
      logic [7:0] expq;
      expq = 8'b1010_0110;
      applyStimulus(1'b1, 8'b1010_0110, 8'hFF);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (sel1 !== 3'(k) || q1 !== expq[k] || qv1 !== 1'b1 || b1 !== 1'b1 || fd1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_ch%0d got sel=%0d q=%b qv=%b busy=%b fd=%b want sel=%0d q=%b qv=1 busy=1 fd=0",
                     k, sel1, q1, qv1, b1, fd1, k, expq[k]);
         end
         tick();
      end
      total++;
      if (fd1 !== 1'b1 || qv1 !== 1'b0 || q1 !== 1'b0 || r1 !== 1'b0 || b1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL full_done got fd=%b qv=%b q=%b rdy=%b busy=%b want 1/0/0/0/0", fd1, qv1, q1, r1, b1);
      end
      tick();
      total++;
      if (fd1 !== 1'b0 || r1 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL full_idle got fd=%b rdy=%b want fd=0 rdy=1", fd1, r1);
      end
   endtask

   task automatic test_masked_dwell3();
      logic [2:0] exps [6];
      exps = '{3'd1, 3'd1, 3'd1, 3'd7, 3'd7, 3'd7};
      v3 = 1'b1; d3 = 8'hFF; m3 = 8'b1000_0010;
      tick();
      v3 = 1'b0; d3 = 8'h00; m3 = 8'h00;
      for (int c = 0; c < 6; c++) begin
         total++;
         if (sel3 !== exps[c] || q3 !== 1'b1 || qv3 !== 1'b1 || fd3 !== 1'b0 || b3 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL masked_cyc%0d got sel=%0d q=%b qv=%b fd=%b busy=%b want sel=%0d q=1 qv=1 fd=0 busy=1",
                     c, sel3, q3, qv3, fd3, b3, exps[c]);
         end
         tick();
      end
      total++;
      if (fd3 !== 1'b1 || qv3 !== 1'b0 || r3 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL masked_done got fd=%b qv=%b rdy=%b want 1/0/0", fd3, qv3, r3);
      end
      tick();
      total++;
      if (fd3 !== 1'b0 || r3 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL masked_idle got fd=%b rdy=%b want 0/1", fd3, r3);
      end
   endtask

   task automatic test_empty_mask();
      applyStimulus(1'b1, 8'hFF, 8'h00);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00);
      total++;
      if (fd1 !== 1'b1 || qv1 !== 1'b0 || r1 !== 1'b0 || b1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL empty_done got fd=%b qv=%b rdy=%b busy=%b want 1/0/0/0", fd1, qv1, r1, b1);
      end
      tick();
      total++;
      if (fd1 !== 1'b0 || qv1 !== 1'b0 || r1 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL empty_idle got fd=%b qv=%b rdy=%b want 0/0/1", fd1, qv1, r1);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exps [2];
      // Frame A: channels 0,1 with q=1; frame B (queued): channels 4,5 with q=1.
      applyStimulus(1'b1, 8'h0F, 8'h03);
      tick();
      applyStimulus(1'b1, 8'hF0, 8'h30);
      exps = '{3'd0, 3'd1};
      for (int c = 0; c < 2; c++) begin
         total++;
         if (sel1 !== exps[c] || q1 !== 1'b1 || qv1 !== 1'b1 || r1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_a_cyc%0d got sel=%0d q=%b qv=%b rdy=%b want sel=%0d q=1 qv=1 rdy=0",
                     c, sel1, q1, qv1, r1, exps[c]);
         end
         tick();
      end
      total++;
      if (fd1 !== 1'b1 || qv1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_a_done got fd=%b qv=%b want 1/0", fd1, qv1);
      end
      tick();
      total++;
      if (r1 !== 1'b1 || fd1 !== 1'b0 || qv1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_gap got rdy=%b fd=%b qv=%b want 1/0/0", r1, fd1, qv1);
      end
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00);
      exps = '{3'd4, 3'd5};
      for (int c = 0; c < 2; c++) begin
         total++;
         if (sel1 !== exps[c] || q1 !== 1'b1 || qv1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_b_cyc%0d got sel=%0d q=%b qv=%b want sel=%0d q=1 qv=1",
                     c, sel1, q1, qv1, exps[c]);
         end
         tick();
      end
      total++;
      if (fd1 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b_b_done got fd=%b want 1", fd1);
      end
      tick();
   endtask

   task automatic test_reset_midscan();
      int fd_seen;
      applyStimulus(1'b1, 8'hFF, 8'hFF);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00);
      for (int c = 0; c < 4; c++) tick();
      total++;
      if (sel1 !== 3'd4 || qv1 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midscan_pre got sel=%0d qv=%b want sel=4 qv=1", sel1, qv1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (qv1 !== 1'b0 || sel1 !== 3'd0 || fd1 !== 1'b0 || b1 !== 1'b0 || r1 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midscan_abort got qv=%b sel=%0d fd=%b busy=%b rdy=%b want 0/0/0/0/1",
                  qv1, sel1, fd1, b1, r1);
      end
      fd_seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (fd1 !== 1'b0 || qv1 !== 1'b0) fd_seen++;
      end
      total++;
      if (fd_seen != 0) begin
         bad++;
         $display("[TB] FAIL midscan_quiet got active_cycles=%0d want 0", fd_seen);
      end
      applyStimulus(1'b1, 8'h01, 8'h01);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00);
      total++;
      if (sel1 !== 3'd0 || q1 !== 1'b1 || qv1 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midscan_new got sel=%0d q=%b qv=%b want 0/1/1", sel1, q1, qv1);
      end
      tick();
      total++;
      if (fd1 !== 1'b1 || qv1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midscan_new_done got fd=%b qv=%b want 1/0", fd1, qv1);
      end
      tick();
   endtask

   initial begin
      $display("[TB] starting");
      test_reset();
      test_full_frame();
      test_masked_dwell3();
      test_empty_mask();
      test_back_to_back();
      test_reset_midscan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux_frame_scanner.md
Name: demux_frame_scanner

Overview:
- Upstream driver for the 1:8 demultiplexer `demuxif`.
- Accepts an 8-bit frame, plus a per-frame channel-enable mask, over a valid/ready handshake.
- Serialises the frame onto the demux inputs: drives `select` and `q` channel by channel, lowest enabled channel first, holding each channel for a programmable dwell time.
- Signals completion so the next frame can be accepted.

Parameters:
- SEL_W, 3, select width; channel count NCH = 2**SEL_W.
- DWELL, 1, clock cycles each enabled channel is held on select/q; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  frame offered.
- in_ready  output  1  block can accept a frame (high exactly when FSM is IDLE).
- in_data  input  NCH  frame bits; bit k goes to channel k.
- in_mask  input  NCH  channel enables; bit k = 0 skips channel k.
- select  output  SEL_W  demux channel select (registered).
- q  output  1  demux data input (registered).
- q_valid  output  1  select/q currently carry a live channel.
- busy  output  1  FSM in SCAN.
- frame_done  output  1  one-cycle pulse after the last enabled channel's dwell ends.

Behaviour:
- Reset (synchronous, sampled at clk edge):
  - FSM = IDLE.
  - select = 0, q = 0, q_valid = 0, busy = 0, frame_done = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-SCAN aborts the frame: no frame_done, no further q_valid; captured data discarded.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1, q_valid = 0, q = 0; select holds its last value.
  - Handshake when in_valid & in_ready at an edge: capture in_data and in_mask into internal registers.
  - If captured mask == 0: go to DONE.
  - Otherwise go to SCAN with select = lowest set mask index, q = in_data[that index], q_valid = 1, dwell counter = 0.
- SCAN:
  - Dwell counter increments each cycle; select/q stay stable for exactly DWELL cycles per channel.
  - When counter reaches DWELL-1, advance to the next set mask bit with higher index.
    - Masked channels take zero cycles.
    - No gap cycle between enabled channels.
  - If no higher set bit exists, go to DONE; q_valid = 0 and q = 0 in that DONE cycle.
- DONE:
  - frame_done = 1 for exactly one cycle; in_ready = 0.
  - Next state is IDLE unconditionally.
- Latency: first q_valid appears the cycle after acceptance.
- Frame period (acceptance to next possible acceptance) = popcount(mask)*DWELL + 2 cycles.
- in_valid while busy is ignored; the upstream source must hold the frame until in_ready.
- Dwell counter width = clog2(DWELL+1); no wrap-around possible.
- select never exceeds NCH-1.
- in_data/in_mask changes during SCAN have no effect.
- All outputs except in_ready are registered. in_ready is decoded from the state register only, never combinationally from in_valid.

Decomposition:
- Package demux_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - constants SEL_W_DEF = 3 and NCH_DEF = 8;
  - function next_set_index(mask, current) returning the next set bit above current plus a found flag.
- One sub-module is natural: demux_prio_find, a combinational next-enabled-channel finder, instantiated once for the first-channel search and reused for the advance search.
- The top level instantiates demux_frame_scanner, feeding the 1:8 demux `demuxif` via select/q.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> select=0, q=0, q_valid=0, busy=0, in_ready=1.
- Full frame, DWELL=1: send in_data=8'b1010_0110, in_mask=8'hFF.
  - Required: select 0..7 on 8 consecutive cycles with q = 0,1,1,0,0,1,0,1.
  - Then frame_done=1 for one cycle, then in_ready=1 (10-cycle period).
- Masked frame, DWELL=3: in_data=8'hFF, in_mask=8'b1000_0010.
  - Required: select=1 with q=1 for 3 cycles, then select=7 with q=1 for 3 cycles, then frame_done pulse.
  - Channels 0 and 2–6 never appear with q_valid.
- Empty mask: in_mask=0 -> no q_valid at all; frame_done exactly 1 cycle after acceptance; in_ready back 2 cycles after acceptance.
- Back-to-back plus busy stimulus: hold in_valid high with two queued frames.
  - Required: second accepted exactly in the cycle after frame_done.
  - in_valid during SCAN produces no capture; frame 1 output is unchanged by frame-2 data.
- Reset mid-scan: assert rst while select=4 in a full-mask frame.
  - Required: next cycle q_valid=0, select=0, no frame_done.
  - A new frame is accepted normally afterwards.
